// File: rtl/mvu_pe_out_collect.sv
// Purpose  : collect PE accumulator vectors into a circular FIFO and drain them on a valid/ready stream.
// Latency  : 1 cycle from in_acc_v to out_v into an empty FIFO; out_dat is first-word-fall-through.
// Backpres.: none upstream; stall_req is raised early and a word arriving while full with no pop is dropped (ovf).
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_acc_v, in_acc  one-cycle PE result pulse and its PE*TDstI lane vector (lane p = [p*TDstI +: TDstI])
//   out_v, out_rdy    output handshake; out_dat is the word at the read pointer
//   count             FIFO occupancy in words
//   stall_req         registered request to hold the accumulator stream (count_next >= DEPTH-2)
//   ovf               sticky drop flag, cleared only by reset
// Optional feature: define MVU_OUT_RELU_EN to clamp negative lanes to zero at push.
module mvu_pe_out_collect #(
  parameter int PE    = 4,
  parameter int TDstI = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_acc_v,
  input  logic [PE*TDstI-1:0]          in_acc,
  output logic                         out_v,
  input  logic                         out_rdy,
  output logic [PE*TDstI-1:0]          out_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         stall_req,
  output logic                         ovf
);

  localparam int W  = PE * TDstI;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  // Two words of headroom absorb results already inside the accumulator pipeline.
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 2);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  logic [W-1:0]  wr_dat;

  // out_v is count!=0 registered, so a word pushed into an empty FIFO
  // cannot be popped in the same cycle.
  assign pop  = out_v && out_rdy;
  // A pop frees a slot this cycle, so a full FIFO can still accept.
  assign push = in_acc_v && ((count < FULL) || pop);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

`ifdef MVU_OUT_RELU_EN
  always_comb begin
    wr_dat = in_acc;
    for (int p = 0; p < PE; p++) begin
      if (in_acc[p*TDstI + TDstI - 1]) begin
        wr_dat[p*TDstI +: TDstI] = '0;
      end
    end
  end
`else
  assign wr_dat = in_acc;
`endif

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_v     <= 1'b0;
      stall_req <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      // Explicit wrap: DEPTH need not be a power of two.
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      count     <= count_next;
      out_v     <= (count_next != '0);
      stall_req <= (count_next >= STALL_AT);
      if (in_acc_v && !push) begin
        ovf <= 1'b1;
      end
    end
  end

  assign out_dat = mem[rd_ptr];

endmodule

// File: tb/tb_mvu_pe_out_collect.sv
module tb_mvu_pe_out_collect;

  localparam int PE    = 2;
  localparam int TDstI = 8;
  localparam int DEPTH = 4;
  localparam int W     = PE * TDstI;

  logic         clock;
  logic         reset;
  logic         in_acc_v;
  logic [W-1:0] in_acc;
  logic         out_rdy;
  logic         out_v;
  logic [W-1:0] out_dat;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic         stall_req;
  logic         ovf;

  logic         out_v5;
  logic [W-1:0] out_dat5;
  logic [$clog2(6)-1:0] count5;
  logic         stall_req5;
  logic         ovf5;

  int checks = 0;
  int errors = 0;

  // Reference state: occupancy and sticky drop flag; data lives in the scoreboard queue.
  int           m_cnt = 0;
  bit           m_ovf = 0;
  bit           chk_en = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp5_q[$];
  bit           act5 = 0;

  mvu_pe_out_collect #(.PE(PE), .TDstI(TDstI), .DEPTH(DEPTH)) u_dut (
    .clock(clock), .reset(reset), .in_acc_v(in_acc_v), .in_acc(in_acc),
    .out_v(out_v), .out_rdy(out_rdy), .out_dat(out_dat), .count(count),
    .stall_req(stall_req), .ovf(ovf)
  );

  mvu_pe_out_collect #(.PE(PE), .TDstI(TDstI), .DEPTH(5)) u_dut5 (
    .clock(clock), .reset(reset), .in_acc_v(in_acc_v), .in_acc(in_acc),
    .out_v(out_v5), .out_rdy(out_rdy), .out_dat(out_dat5), .count(count5),
    .stall_req(stall_req5), .ovf(ovf5)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] relu(logic [W-1:0] w);
    logic [W-1:0] r;
    r = w;
`ifdef MVU_OUT_RELU_EN
    for (int p = 0; p < PE; p++) begin
      if ($signed(w[p*TDstI +: TDstI]) < 0) r[p*TDstI +: TDstI] = '0;
    end
`endif
    return r;
  endfunction

  // Drive one cycle: check status mid-cycle against the model, then advance the model at the edge.
  task automatic step(input bit rst, input bit v, input logic [W-1:0] d, input bit r);
    bit pop;
    bit push;
    reset    = rst;
    in_acc_v = v;
    in_acc   = d;
    out_rdy  = r;
    @(negedge clock);
    if (chk_en) begin
      check("count", 32'(count), 32'(m_cnt));
      check("out_v", 32'(out_v), 32'(m_cnt != 0));
      check("stall_req", 32'(stall_req), 32'(m_cnt >= DEPTH - 2));
      check("ovf", 32'(ovf), 32'(m_ovf));
    end
    @(posedge clock);
    if (rst) begin
      m_cnt  = 0;
      m_ovf  = 0;
      chk_en = 1;
      exp_q.delete();
    end else begin
      pop  = (m_cnt > 0) && r;
      push = v && ((m_cnt < DEPTH) || pop);
      m_cnt = m_cnt + int'(push) - int'(pop);
      if (push) exp_q.push_back(relu(d));
      if (v && !push) m_ovf = 1;
    end
    #1;
  endtask

  // Scoreboard monitor: the head word must be presented whenever out_v is high,
  // held while stalled, and retired on a handshake.
  always @(negedge clock) begin
    if (chk_en && !reset && out_v) begin
      if (exp_q.size() == 0) begin
        check("ghost_word", 32'(out_dat), 32'hFFFF_FFFF);
      end else begin
        check("out_dat", 32'(out_dat), 32'(exp_q[0]));
        if (out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (act5) begin
      check("d5_count_le1", 32'(count5 <= 1), 32'd1);
      check("d5_ovf", 32'(ovf5), 32'd0);
      if (out_v5 && out_rdy) begin
        if (exp5_q.size() == 0) check("d5_ghost", 32'(out_dat5), 32'hFFFF_FFFF);
        else check("d5_out_dat", 32'(out_dat5), 32'(exp5_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; in_acc_v = 1'b0; in_acc = '0; out_rdy = 1'b0;
    #1;

    // 1: reset held with in_acc_v high, then idle: no ghost words.
    for (int i = 0; i < 3; i++) step(1, 1, 16'h1234 + W'(i), 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1);

    // 2: three pushes with out_rdy low, hold, then drain.
    step(0, 1, 16'h0201, 0);
    step(0, 1, 16'h0403, 0);
    step(0, 1, 16'h0605, 0);
    for (int i = 0; i < 2; i++) step(0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1);

    // 3: overflow by a fifth word while blocked, then drain; ovf sticks.
    for (int i = 0; i < 4; i++) step(0, 1, 16'h1111 * W'(i + 1), 0);
    step(0, 1, 16'hAAAA, 0);
    for (int i = 0; i < 2; i++) step(0, 0, '0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

    // 4: full FIFO, simultaneous pop and push.
    for (int i = 0; i < 4; i++) step(0, 1, 16'h0A00 + W'(i), 0);
    step(0, 1, 16'h5555, 1);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1);
    step(1, 0, '0, 1);
    step(0, 0, '0, 1);

    // 5: continuous streaming through both depths.
    for (int i = 0; i < 12; i++) exp5_q.push_back(relu(W'(i)));
    act5 = 1;
    for (int i = 0; i < 12; i++) step(0, 1, W'(i), 1);
    for (int i = 0; i < 2; i++) step(0, 0, '0, 1);
    act5 = 0;
    check("d5_drained", 32'(exp5_q.size()), 32'd0);

    // 6: signed lanes (ReLU when enabled).
    step(0, 1, 16'hFB05, 0);
    step(0, 1, 16'h7F80, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
           W'($urandom), $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
